// File: rtl/sim_top.sv
// Banner/echo UART controller with cycle-windowed perf dump.
// All outputs come from flops; nothing on an input reaches an output in the same cycle.
//
// state  | meaning
// BANNER | stepping through the banner ROM, one character per transmit slot
// ECHO   | polling uart input every cycle and echoing through a 1-entry buffer
module sim_top #(
    parameter int MSG_LEN = 13,
    parameter int SLOT    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] io_logCtrl_log_begin,
    input  logic [63:0] io_logCtrl_log_end,
    input  logic [63:0] io_logCtrl_log_level,
    input  logic        io_perfInfo_clean,
    input  logic        io_perfInfo_dump,
    output logic        io_uart_out_valid,
    output logic [7:0]  io_uart_out_ch,
    output logic        io_uart_in_valid,
    input  logic [7:0]  io_uart_in_ch
);

    localparam int SLOT_W = $clog2(SLOT);
    localparam int IDX_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    typedef enum logic {
        BANNER = 1'b0,
        ECHO   = 1'b1
    } state_t;

    state_t             state;
    logic [63:0]        cyc;
    logic [31:0]        perf;
    logic [IDX_W-1:0]   banner_idx;
    logic               banner_done;
    logic [7:0]         echo_buf;
    logic               echo_full;
    logic               dump_pend;
    logic               out_valid_q;
    logic [7:0]         out_ch_q;

    logic               slot_next;
    logic               inwin;
    logic               dump_ok;
    logic               dump_take;
    logic               in_accept;
    logic [31:0]        idx32;
    logic [7:0]         rom_ch;

    // The output flops load on the edge that enters the slot cycle,
    // so the slot is detected one cycle early.
    assign slot_next = (cyc[SLOT_W-1:0] == SLOT_W'(SLOT - 2));

    assign inwin = (io_logCtrl_log_end != 64'd0) &&
                   (io_logCtrl_log_begin <= cyc) &&
                   (cyc < io_logCtrl_log_end);

    assign dump_ok   = io_perfInfo_dump && ((|io_logCtrl_log_level) || inwin);
    assign dump_take = slot_next && (dump_pend || dump_ok);
    assign in_accept = (state == ECHO) && (io_uart_in_ch != 8'hFF) && !echo_full;

    assign idx32 = 32'(banner_idx);

    always_comb begin
        rom_ch = 8'h00;
        case (idx32)
            32'd0:   rom_ch = 8'h48;  // H
            32'd1:   rom_ch = 8'h65;  // e
            32'd2:   rom_ch = 8'h6C;  // l
            32'd3:   rom_ch = 8'h6C;  // l
            32'd4:   rom_ch = 8'h6F;  // o
            32'd5:   rom_ch = 8'h20;
            32'd6:   rom_ch = 8'h53;  // S
            32'd7:   rom_ch = 8'h69;  // i
            32'd8:   rom_ch = 8'h6D;  // m
            32'd9:   rom_ch = 8'h54;  // T
            32'd10:  rom_ch = 8'h6F;  // o
            32'd11:  rom_ch = 8'h70;  // p
            32'd12:  rom_ch = 8'h0A;  // newline
            default: rom_ch = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= BANNER;
            cyc         <= 64'd0;
            perf        <= 32'd0;
            banner_idx  <= '0;
            banner_done <= 1'b0;
            echo_buf    <= 8'h00;
            echo_full   <= 1'b0;
            dump_pend   <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= 8'h00;
        end else begin
            cyc <= cyc + 64'd1;

            // Clean zeroes first; an emission in the same cycle still counts.
            if (io_perfInfo_clean)
                perf <= {31'd0, out_valid_q};
            else
                perf <= perf + {31'd0, out_valid_q};

            out_valid_q <= 1'b0;
            out_ch_q    <= 8'h00;

            if (dump_ok)
                dump_pend <= 1'b1;

            if (dump_take) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= io_perfInfo_clean ? 8'h00 : perf[7:0];
                dump_pend   <= 1'b0;
            end else if (slot_next) begin
                if (state == BANNER && !banner_done) begin
                    out_valid_q <= 1'b1;
                    out_ch_q    <= rom_ch;
                    banner_idx  <= banner_idx + IDX_W'(1);
                    if (banner_idx == IDX_W'(MSG_LEN - 1))
                        banner_done <= 1'b1;
                end else if (state == ECHO && echo_full) begin
                    out_valid_q <= 1'b1;
                    out_ch_q    <= echo_buf;
                    echo_full   <= 1'b0;
                end
            end

            // Last banner character has gone out; switch over on the following cycle.
            if (state == BANNER && banner_done) begin
                state       <= ECHO;
                banner_done <= 1'b0;
            end

            if (in_accept) begin
                echo_buf  <= io_uart_in_ch;
                echo_full <= 1'b1;
            end
        end
    end

    assign io_uart_out_valid = out_valid_q;
    assign io_uart_out_ch    = out_ch_q;
    assign io_uart_in_valid  = (state == ECHO);

endmodule

// File: tb/tb_sim_top.sv
// Scoreboard bench for sim_top: expected characters are queued with their
// emission cycle as stimulus is driven, and a negedge monitor pops and compares.
module tb_sim_top;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] log_begin = 64'd0;
    logic [63:0] log_end   = 64'd0;
    logic [63:0] log_level = 64'd0;
    logic        clean = 1'b0;
    logic        dump  = 1'b0;
    logic        out_valid;
    logic [7:0]  out_ch;
    logic        in_valid;
    logic [7:0]  in_ch = 8'hFF;

    always #5 clock = ~clock;

    sim_top dut (
        .clock                (clock),
        .reset                (reset),
        .io_logCtrl_log_begin (log_begin),
        .io_logCtrl_log_end   (log_end),
        .io_logCtrl_log_level (log_level),
        .io_perfInfo_clean    (clean),
        .io_perfInfo_dump     (dump),
        .io_uart_out_valid    (out_valid),
        .io_uart_out_ch       (out_ch),
        .io_uart_in_valid     (in_valid),
        .io_uart_in_ch        (in_ch)
    );

    typedef struct {
        longint unsigned c;
        logic [7:0]      ch;
    } exp_t;

    exp_t            exp_q[$];
    int              n_cmp = 0;
    int              n_err = 0;
    longint unsigned tb_cyc = 0;
    logic [7:0]      banner_rom [0:12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h53,
                                           8'h69, 8'h6D, 8'h54, 8'h6F, 8'h70, 8'h0A};

    // Reference cycle count: 0 in the first cycle after reset drops.
    always @(posedge clock) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL uart_out unexpected: cyc=%0d ch=%02h, required no output", tb_cyc, out_ch);
            end else begin
                e = exp_q.pop_front();
                if (e.c !== tb_cyc || e.ch !== out_ch) begin
                    n_err++;
                    $display("FAIL uart_out: cyc=%0d ch=%02h, required cyc=%0d ch=%02h",
                             tb_cyc, out_ch, e.c, e.ch);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_cyc(input longint unsigned n);
        int guard = 0;
        @(negedge clock);
        while (tb_cyc != n && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        if (tb_cyc != n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_cyc: cyc=%0d, required %0d", tb_cyc, n);
        end
    endtask

    task automatic push_exp(input longint unsigned c, input logic [7:0] ch);
        exp_t e;
        e.c  = c;
        e.ch = ch;
        exp_q.push_back(e);
    endtask

    task automatic push_banner();
        for (int i = 0; i < 13; i++)
            push_exp(longint'(3 + 4 * i), banner_rom[i]);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_dump(input longint unsigned n);
        wait_cyc(n);
        dump = 1'b1;
        @(posedge clock);
        #1 dump = 1'b0;
    endtask

    task automatic pulse_clean(input longint unsigned n);
        wait_cyc(n);
        clean = 1'b1;
        @(posedge clock);
        #1 clean = 1'b0;
    endtask

    task automatic send_char(input longint unsigned n, input logic [7:0] ch);
        wait_cyc(n);
        in_ch = ch;
        @(posedge clock);
        #1 in_ch = 8'hFF;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_cmp++;
        if (out_ch !== 8'h00) begin
            n_err++;
            $display("FAIL reset_out_ch: got %02h, required 00", out_ch);
        end
        n_cmp++;
        if (in_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_valid: got %b, required 0", in_valid);
        end
    endtask

    task automatic test_banner();
        push_banner();
        @(posedge clock);
        #1 reset = 1'b0;
        wait_cyc(51);
        n_cmp++;
        if (in_valid !== 1'b0) begin
            n_err++;
            $display("FAIL banner_in_valid_51: got %b, required 0", in_valid);
        end
        wait_cyc(52);
        n_cmp++;
        if (in_valid !== 1'b1) begin
            n_err++;
            $display("FAIL banner_in_valid_52: got %b, required 1", in_valid);
        end
        wait_cyc(58);
        n_cmp++;
        if (in_valid !== 1'b1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL banner_done: in_valid=%b pending=%0d, required 1 and 0", in_valid, exp_q.size());
        end
    endtask

    task automatic test_echo();
        push_exp(63, 8'h41);
        send_char(60, 8'h41);
        push_exp(75, 8'h42);
        send_char(72, 8'h42);
        send_char(73, 8'h43);
        log_level = 64'd1;
        // dump and echo collide: dump wins the slot, echo takes the next one
        push_exp(83, 8'h0F);
        push_exp(87, 8'h44);
        wait_cyc(80);
        in_ch = 8'h44;
        dump  = 1'b1;
        @(posedge clock);
        #1;
        in_ch = 8'hFF;
        dump  = 1'b0;
        wait_cyc(95);
        n_cmp++;
        if (exp_q.size() != 0 || in_valid !== 1'b1) begin
            n_err++;
            $display("FAIL echo_done: pending=%0d in_valid=%b, required 0 and 1", exp_q.size(), in_valid);
            exp_q.delete();
        end
    endtask

    task automatic test_dump_level();
        do_reset();
        log_level = 64'd1;
        log_begin = 64'd0;
        log_end   = 64'd0;
        push_banner();
        push_exp(63, 8'h0D);
        pulse_dump(60);
        wait_cyc(70);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL dump_level_done: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_dump_window();
        do_reset();
        log_level = 64'd0;
        log_begin = 64'd100;
        log_end   = 64'd200;
        push_banner();
        pulse_dump(50);
        push_exp(103, 8'h0D);
        pulse_dump(100);
        push_exp(151, 8'h0E);
        pulse_dump(150);
        pulse_dump(200);
        wait_cyc(205);
        log_begin = 64'd0;
        log_end   = 64'd0;
        pulse_dump(210);
        wait_cyc(230);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL dump_window_done: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clean();
        do_reset();
        log_level = 64'd0;
        log_begin = 64'd0;
        log_end   = 64'd0;
        push_banner();
        pulse_clean(20);
        log_level = 64'd1;
        push_exp(63, 8'h08);
        pulse_dump(60);
        pulse_clean(63);
        push_exp(71, 8'h01);
        pulse_dump(70);
        push_exp(83, 8'h00);
        wait_cyc(80);
        clean = 1'b1;
        dump  = 1'b1;
        @(posedge clock);
        #1;
        clean = 1'b0;
        dump  = 1'b0;
        push_exp(91, 8'h01);
        pulse_dump(90);
        push_exp(95, 8'h00);
        wait_cyc(94);
        clean = 1'b1;
        dump  = 1'b1;
        @(posedge clock);
        #1;
        clean = 1'b0;
        dump  = 1'b0;
        wait_cyc(100);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL clean_done: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        log_level = 64'd0;
        for (int i = 0; i < 6; i++)
            push_exp(longint'(3 + 4 * i), banner_rom[i]);
        wait_cyc(25);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (out_valid !== 1'b0 || in_valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_mid_abort: out_valid=%b in_valid=%b pending=%0d, required 0 0 0",
                     out_valid, in_valid, exp_q.size());
            exp_q.delete();
        end
        push_banner();
        wait_cyc(60);
        n_cmp++;
        if (exp_q.size() != 0 || in_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_restart: pending=%0d in_valid=%b, required 0 and 1",
                     exp_q.size(), in_valid);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_banner();
        test_echo();
        test_dump_level();
        test_dump_window();
        test_clean();
        test_reset_mid();
        repeat (4) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
